axis_route_upsizer: RTL and testbench



---
 rtl/axis_route_upsizer_if.sv | 32 +++
 rtl/axis_route_upsizer.sv | 184 ++++++++++++++++++
 tb/tb_axis_route_upsizer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_route_upsizer_if.sv
// Stream bundle for the route upsizer: narrow input beats in, wide routed words out.
interface axis_route_upsizer_if #(
    parameter int IN_W    = 128,
    parameter int RATIO   = 12,
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 2,
    parameter int OUT_W   = IN_W * RATIO,
    parameter int CNT_W   = $clog2(RATIO + 1)
);
    logic [NUM_IN*IN_W-1:0]   s_tdata;
    logic [NUM_IN-1:0]        s_tvalid;
    logic [NUM_IN-1:0]        s_tlast;
    logic [NUM_IN-1:0]        s_tready;

    logic [NUM_OUT*OUT_W-1:0] m_tdata;
    logic [NUM_OUT*CNT_W-1:0] m_tcount;
    logic [NUM_OUT-1:0]       m_tvalid;
    logic [NUM_OUT-1:0]       m_tlast;
    logic [NUM_OUT-1:0]       m_tready;

    // the upsizer itself: consumes narrow beats, produces wide words
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tcount, m_tvalid, m_tlast
    );

    // the surrounding system: produces narrow beats, consumes wide words
    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tcount, m_tvalid, m_tlast
    );
endinterface

// File: rtl/axis_route_upsizer.sv
// Gathers RATIO narrow beats per channel into a wide word, queues it in a
// 2-deep channel FIFO, and routes FIFO heads to wide outputs through a
// runtime crossbar that can broadcast one source to several outputs.
module axis_route_upsizer #(
    parameter int IN_W    = 128,
    parameter int RATIO   = 12,
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 2,
    parameter int SEL_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    parameter int CNT_W   = $clog2(RATIO + 1),
    parameter int OUT_W   = IN_W * RATIO
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_OUT*(1+SEL_W)-1:0] ctrl,
    input  logic                         ctrl_load,
    output logic                         busy,
    axis_route_upsizer_if.slave          bus
);
    localparam int FW = 1 + SEL_W;
    localparam int EW = OUT_W + CNT_W + 1;  // queued word {last, count, data}

    logic [OUT_W-1:0]         acc_q    [NUM_IN];
    logic [CNT_W-1:0]         beat_q   [NUM_IN];
    logic [EW-1:0]            stg_q    [NUM_IN];
    logic [NUM_IN-1:0]        stg_vld_q;
    logic [EW-1:0]            fifo_q   [NUM_IN][2];
    logic [NUM_IN-1:0]        wr_q, rd_q;
    logic [1:0]               lvl_q    [NUM_IN];
    logic                     rdy_en_q;

    logic [NUM_OUT*FW-1:0]    route_q, pend_q;
    logic                     busy_q;

    logic [NUM_OUT*OUT_W-1:0] m_data_q;
    logic [NUM_OUT*CNT_W-1:0] m_cnt_q;
    logic [NUM_OUT-1:0]       m_vld_q, m_last_q;

    logic [NUM_IN-1:0]        s_rdy, accept, close, pop, want, blk;
    logic [OUT_W-1:0]         word_d   [NUM_IN];
    logic [NUM_OUT-1:0]       en_eff, free, load;
    logic [SEL_W-1:0]         sel      [NUM_OUT];
    logic [EW-1:0]            src_word [NUM_OUT];
    logic                     apply;

    // Input acceptance and lane merge; the staged word counts toward fullness
    // so it always has a FIFO slot on the following edge.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            s_rdy[i]  = rdy_en_q & ~((lvl_q[i] == 2'd2) | ((lvl_q[i] != 2'd0) & stg_vld_q[i]));
            accept[i] = bus.s_tvalid[i] & s_rdy[i];
            close[i]  = accept[i] & (bus.s_tlast[i] | (beat_q[i] == CNT_W'(RATIO - 1)));
            for (int k = 0; k < RATIO; k++) begin
                word_d[i][k*IN_W +: IN_W] = (beat_q[i] == CNT_W'(k)) ?
                    bus.s_tdata[i*IN_W +: IN_W] : acc_q[i][k*IN_W +: IN_W];
            end
        end
    end

    // Accumulators: clear on close so lanes above an early close stay zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en_q  <= 1'b0;
            stg_vld_q <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                acc_q[i]  <= '0;
                beat_q[i] <= '0;
                stg_q[i]  <= '0;
            end
        end else begin
            rdy_en_q <= 1'b1;
            for (int i = 0; i < NUM_IN; i++) begin
                stg_vld_q[i] <= close[i];
                if (close[i]) begin
                    stg_q[i]  <= {bus.s_tlast[i], beat_q[i] + CNT_W'(1), word_d[i]};
                    acc_q[i]  <= '0;
                    beat_q[i] <= '0;
                end else if (accept[i]) begin
                    acc_q[i]  <= word_d[i];
                    beat_q[i] <= beat_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Two-entry channel FIFOs fed from the staging register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                lvl_q[i]     <= '0;
                fifo_q[i][0] <= '0;
                fifo_q[i][1] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (stg_vld_q[i]) begin
                    fifo_q[i][wr_q[i]] <= stg_q[i];
                    wr_q[i]            <= ~wr_q[i];
                end
                if (pop[i]) rd_q[i] <= ~rd_q[i];
                lvl_q[i] <= lvl_q[i] + {1'b0, stg_vld_q[i]} - {1'b0, pop[i]};
            end
        end
    end

    // Crossbar: a head pops only when every enabled output selecting it is free;
    // out-of-range selects count as disabled, and nothing pops on a route swap.
    always_comb begin
        apply = busy_q & ~|m_vld_q;
        for (int o = 0; o < NUM_OUT; o++) begin
            sel[o]    = route_q[o*FW +: SEL_W];
            en_eff[o] = route_q[o*FW + SEL_W] & (32'(sel[o]) < 32'(NUM_IN));
            free[o]   = ~m_vld_q[o] | bus.m_tready[o];
        end
        for (int i = 0; i < NUM_IN; i++) begin
            want[i] = 1'b0;
            blk[i]  = 1'b0;
            for (int o = 0; o < NUM_OUT; o++) begin
                if (en_eff[o] && sel[o] == SEL_W'(i)) begin
                    want[i] = 1'b1;
                    if (!free[o]) blk[i] = 1'b1;
                end
            end
            pop[i] = (lvl_q[i] != 2'd0) & want[i] & ~blk[i] & ~apply;
        end
        for (int o = 0; o < NUM_OUT; o++) begin
            load[o]     = 1'b0;
            src_word[o] = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel[o] == SEL_W'(i)) begin
                    load[o]     = en_eff[o] & pop[i];
                    src_word[o] = fifo_q[i][rd_q[i]];
                end
            end
        end
    end

    // Route registers: a new load always wins, even on the swap edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            route_q <= '0;
            pend_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            if (apply) route_q <= pend_q;
            if (ctrl_load) begin
                pend_q <= ctrl;
                busy_q <= 1'b1;
            end else if (apply) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Output slots: load on pop, drop valid on acceptance, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_q <= '0;
            m_cnt_q  <= '0;
            m_vld_q  <= '0;
            m_last_q <= '0;
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                if (load[o]) begin
                    m_data_q[o*OUT_W +: OUT_W] <= src_word[o][OUT_W-1:0];
                    m_cnt_q[o*CNT_W +: CNT_W]  <= src_word[o][OUT_W +: CNT_W];
                    m_last_q[o]                <= src_word[o][EW-1];
                    m_vld_q[o]                 <= 1'b1;
                end else if (bus.m_tready[o]) begin
                    m_vld_q[o] <= 1'b0;
                end
            end
        end
    end

    assign bus.s_tready = s_rdy;
    assign bus.m_tdata  = m_data_q;
    assign bus.m_tcount = m_cnt_q;
    assign bus.m_tvalid = m_vld_q;
    assign bus.m_tlast  = m_last_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_axis_route_upsizer.sv
// Directed bench for axis_route_upsizer with two channels and two outputs.
module tb_axis_route_upsizer;
    localparam int IN_W    = 128;
    localparam int RATIO   = 12;
    localparam int NUM_IN  = 2;
    localparam int NUM_OUT = 2;
    localparam int CNT_W   = 4;
    localparam int OUT_W   = IN_W * RATIO;

    logic       clk, rst, ctrl_load, busy;
    logic [3:0] ctrl;
    int         n_checks, n_fail;

    axis_route_upsizer_if #(.IN_W(IN_W), .RATIO(RATIO), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) bus ();

    axis_route_upsizer #(.IN_W(IN_W), .RATIO(RATIO), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl), .ctrl_load(ctrl_load), .busy(busy), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] make_word(input logic [15:0] base, input int n);
        logic [OUT_W-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[k*IN_W +: IN_W] = 128'(base) + 128'(k);
        return w;
    endfunction

    task automatic send_beat(input int ch, input logic [127:0] d, input logic last);
        int t;
        t = 0;
        bus.s_tdata[ch*IN_W +: IN_W] = d;
        bus.s_tlast[ch]  = last;
        bus.s_tvalid[ch] = 1'b1;
        while (bus.s_tready[ch] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 100) begin
            n_fail++;
            $display("FAIL send_ready ch%0d: got s_tready=0 required 1 within 100 cycles", ch);
        end else begin
            @(negedge clk);
        end
        bus.s_tvalid[ch] = 1'b0;
        bus.s_tlast[ch]  = 1'b0;
    endtask

    task automatic send_word(input int ch, input logic [15:0] base, input int n, input logic last);
        for (int k = 0; k < n; k++) send_beat(ch, 128'(base) + 128'(k), last && (k == n - 1));
    endtask

    task automatic load_route(input logic [3:0] val);
        ctrl      = val;
        ctrl_load = 1'b1;
        @(negedge clk);
        ctrl_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; ctrl = '0; ctrl_load = 1'b0;
        bus.s_tdata = '0; bus.s_tvalid = '0; bus.s_tlast = '0; bus.m_tready = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b00) begin n_fail++; $display("FAIL rst_tvalid: got %0h required 0", bus.m_tvalid); end
        n_checks++; if (bus.m_tlast !== 2'b00) begin n_fail++; $display("FAIL rst_tlast: got %0h required 0", bus.m_tlast); end
        n_checks++; if (bus.m_tdata !== '0) begin n_fail++; $display("FAIL rst_tdata: got nonzero required 0"); end
        n_checks++; if (bus.m_tcount !== '0) begin n_fail++; $display("FAIL rst_tcount: got %0h required 0", bus.m_tcount); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy); end
        n_checks++; if (bus.s_tready !== 2'b00) begin n_fail++; $display("FAIL rst_tready: got %0b required 00", bus.s_tready); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.s_tready !== 2'b00) begin n_fail++; $display("FAIL release_tready: got %0b required 00", bus.s_tready); end
        @(negedge clk);
        n_checks++; if (bus.s_tready !== 2'b11) begin n_fail++; $display("FAIL first_edge_tready: got %0b required 11", bus.s_tready); end
    endtask

    task automatic test_basic_upsize();
        load_route(4'b1011);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %0b required 0", busy); end
        bus.m_tready = 2'b00;
        send_word(0, 16'h0000, 12, 1'b0);
        n_checks++; if (bus.m_tvalid !== 2'b00) begin n_fail++; $display("FAIL basic_lat0: got %0b required 00", bus.m_tvalid); end
        @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b00) begin n_fail++; $display("FAIL basic_lat1: got %0b required 00", bus.m_tvalid); end
        @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b10) begin n_fail++; $display("FAIL basic_lat2: got %0b required 10", bus.m_tvalid); end
        n_checks++; if (bus.m_tdata[OUT_W +: OUT_W] !== make_word(16'h0000, 12)) begin n_fail++; $display("FAIL basic_data: got %0h required %0h", bus.m_tdata[OUT_W +: OUT_W], make_word(16'h0000, 12)); end
        n_checks++; if (bus.m_tcount[CNT_W +: CNT_W] !== 4'd12) begin n_fail++; $display("FAIL basic_count: got %0d required 12", bus.m_tcount[CNT_W +: CNT_W]); end
        n_checks++; if (bus.m_tlast[1] !== 1'b0) begin n_fail++; $display("FAIL basic_last: got %0b required 0", bus.m_tlast[1]); end
        bus.m_tready = 2'b10;
        @(negedge clk);
        bus.m_tready = 2'b00;
        n_checks++; if (bus.m_tvalid !== 2'b00) begin n_fail++; $display("FAIL basic_accept: got %0b required 00", bus.m_tvalid); end
    endtask

    task automatic test_early_close();
        send_word(0, 16'h0100, 5, 1'b1);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b10) begin n_fail++; $display("FAIL early_valid: got %0b required 10", bus.m_tvalid); end
        n_checks++; if (bus.m_tcount[CNT_W +: CNT_W] !== 4'd5) begin n_fail++; $display("FAIL early_count: got %0d required 5", bus.m_tcount[CNT_W +: CNT_W]); end
        n_checks++; if (bus.m_tlast[1] !== 1'b1) begin n_fail++; $display("FAIL early_last: got %0b required 1", bus.m_tlast[1]); end
        n_checks++; if (bus.m_tdata[OUT_W + 640 +: 896] !== '0) begin n_fail++; $display("FAIL early_upper_zero: got %0h required 0", bus.m_tdata[OUT_W + 640 +: 896]); end
        n_checks++; if (bus.m_tdata[OUT_W +: OUT_W] !== make_word(16'h0100, 5)) begin n_fail++; $display("FAIL early_data: got %0h required %0h", bus.m_tdata[OUT_W +: OUT_W], make_word(16'h0100, 5)); end
        bus.m_tready = 2'b10;
        @(negedge clk);
        bus.m_tready = 2'b00;
    endtask

    task automatic test_broadcast();
        load_route(4'b1010);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bc_busy: got %0b required 0", busy); end
        bus.m_tready = 2'b01;
        send_word(0, 16'h1000, 12, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b11) begin n_fail++; $display("FAIL bc_first_valid: got %0b required 11", bus.m_tvalid); end
        n_checks++; if (bus.m_tdata[0 +: OUT_W] !== make_word(16'h1000, 12)) begin n_fail++; $display("FAIL bc_first_out0: got %0h required %0h", bus.m_tdata[0 +: OUT_W], make_word(16'h1000, 12)); end
        n_checks++; if (bus.m_tdata[OUT_W +: OUT_W] !== make_word(16'h1000, 12)) begin n_fail++; $display("FAIL bc_first_out1: got %0h required %0h", bus.m_tdata[OUT_W +: OUT_W], make_word(16'h1000, 12)); end
        send_word(0, 16'h2000, 12, 1'b0);
        send_word(0, 16'h3000, 12, 1'b0);
        n_checks++; if (bus.s_tready[0] !== 1'b0) begin n_fail++; $display("FAIL bc_full_ready: got %0b required 0", bus.s_tready[0]); end
        repeat (5) @(negedge clk);
        n_checks++; if (bus.s_tready[0] !== 1'b0) begin n_fail++; $display("FAIL bc_full_ready_hold: got %0b required 0", bus.s_tready[0]); end
        n_checks++; if (bus.m_tvalid !== 2'b10) begin n_fail++; $display("FAIL bc_stall_valid: got %0b required 10", bus.m_tvalid); end
        n_checks++; if (bus.m_tdata[OUT_W +: OUT_W] !== make_word(16'h1000, 12)) begin n_fail++; $display("FAIL bc_stall_hold: got %0h required %0h", bus.m_tdata[OUT_W +: OUT_W], make_word(16'h1000, 12)); end
        bus.m_tready = 2'b11;
        @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b11) begin n_fail++; $display("FAIL bc_w2_valid: got %0b required 11", bus.m_tvalid); end
        n_checks++; if (bus.m_tdata[0 +: OUT_W] !== make_word(16'h2000, 12)) begin n_fail++; $display("FAIL bc_w2_out0: got %0h required %0h", bus.m_tdata[0 +: OUT_W], make_word(16'h2000, 12)); end
        n_checks++; if (bus.m_tdata[OUT_W +: OUT_W] !== make_word(16'h2000, 12)) begin n_fail++; $display("FAIL bc_w2_out1: got %0h required %0h", bus.m_tdata[OUT_W +: OUT_W], make_word(16'h2000, 12)); end
        @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b11) begin n_fail++; $display("FAIL bc_w3_valid: got %0b required 11", bus.m_tvalid); end
        n_checks++; if (bus.m_tdata[0 +: OUT_W] !== make_word(16'h3000, 12)) begin n_fail++; $display("FAIL bc_w3_out0: got %0h required %0h", bus.m_tdata[0 +: OUT_W], make_word(16'h3000, 12)); end
        n_checks++; if (bus.m_tdata[OUT_W +: OUT_W] !== make_word(16'h3000, 12)) begin n_fail++; $display("FAIL bc_w3_out1: got %0h required %0h", bus.m_tdata[OUT_W +: OUT_W], make_word(16'h3000, 12)); end
        @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b00) begin n_fail++; $display("FAIL bc_drained: got %0b required 00", bus.m_tvalid); end
        bus.m_tready = 2'b00;
    endtask

    task automatic test_route_change();
        send_word(0, 16'h4000, 12, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b11) begin n_fail++; $display("FAIL rc_held: got %0b required 11", bus.m_tvalid); end
        load_route(4'b0011);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rc_busy_set: got %0b required 1", busy); end
        send_word(1, 16'h5000, 12, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rc_busy_hold: got %0b required 1", busy); end
        n_checks++; if (bus.m_tdata[0 +: OUT_W] !== make_word(16'h4000, 12)) begin n_fail++; $display("FAIL rc_old_route: got %0h required %0h", bus.m_tdata[0 +: OUT_W], make_word(16'h4000, 12)); end
        bus.m_tready = 2'b01;
        @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b10 || busy !== 1'b1) begin n_fail++; $display("FAIL rc_partial: got valid=%0b busy=%0b required valid=10 busy=1", bus.m_tvalid, busy); end
        bus.m_tready = 2'b10;
        @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL rc_empty: got valid=%0b busy=%0b required valid=00 busy=1", bus.m_tvalid, busy); end
        bus.m_tready = 2'b11;
        @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rc_apply: got valid=%0b busy=%0b required valid=00 busy=0", bus.m_tvalid, busy); end
        @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b01) begin n_fail++; $display("FAIL rc_new_valid: got %0b required 01", bus.m_tvalid); end
        n_checks++; if (bus.m_tdata[0 +: OUT_W] !== make_word(16'h5000, 12)) begin n_fail++; $display("FAIL rc_new_data: got %0h required %0h", bus.m_tdata[0 +: OUT_W], make_word(16'h5000, 12)); end
        @(negedge clk);
        bus.m_tready = 2'b00;
    endtask

    task automatic test_disabled();
        int n0, n1;
        logic [OUT_W-1:0] s0 [2];
        logic [OUT_W-1:0] s1 [2];
        n0 = 0; n1 = 0;
        s0[0] = '0; s0[1] = '0; s1[0] = '0; s1[1] = '0;
        load_route(4'b0000);
        bus.m_tready = 2'b11;
        send_word(0, 16'h7000, 12, 1'b0);
        send_word(0, 16'h8000, 12, 1'b0);
        n_checks++; if (bus.s_tready[0] !== 1'b0) begin n_fail++; $display("FAIL dis_ready0: got %0b required 0", bus.s_tready[0]); end
        send_word(1, 16'h9000, 12, 1'b0);
        send_word(1, 16'hA000, 12, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++; if (bus.s_tready !== 2'b00) begin n_fail++; $display("FAIL dis_ready_both: got %0b required 00", bus.s_tready); end
        n_checks++; if (bus.m_tvalid !== 2'b00) begin n_fail++; $display("FAIL dis_no_valid: got %0b required 00", bus.m_tvalid); end
        load_route(4'b1110);
        for (int c = 0; c < 12; c++) begin
            if (bus.m_tvalid[0] === 1'b1) begin if (n0 < 2) s0[n0] = bus.m_tdata[0 +: OUT_W]; n0++; end
            if (bus.m_tvalid[1] === 1'b1) begin if (n1 < 2) s1[n1] = bus.m_tdata[OUT_W +: OUT_W]; n1++; end
            @(negedge clk);
        end
        n_checks++; if (n0 != 2 || n1 != 2) begin n_fail++; $display("FAIL dis_drain_count: got %0d/%0d required 2/2", n0, n1); end
        n_checks++; if (s0[0] !== make_word(16'h7000, 12) || s0[1] !== make_word(16'h8000, 12)) begin n_fail++; $display("FAIL dis_drain_out0: got lane0 %0h,%0h required 7000,8000", s0[0][127:0], s0[1][127:0]); end
        n_checks++; if (s1[0] !== make_word(16'h9000, 12) || s1[1] !== make_word(16'hA000, 12)) begin n_fail++; $display("FAIL dis_drain_out1: got lane0 %0h,%0h required 9000,a000", s1[0][127:0], s1[1][127:0]); end
        n_checks++; if (bus.s_tready !== 2'b11) begin n_fail++; $display("FAIL dis_ready_back: got %0b required 11", bus.s_tready); end
        bus.m_tready = 2'b00;
    endtask

    task automatic test_reset_mid_word();
        send_word(1, 16'hB000, 12, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b10) begin n_fail++; $display("FAIL rm_pre_valid: got %0b required 10", bus.m_tvalid); end
        send_word(0, 16'hC000, 7, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.m_tvalid !== 2'b00 || bus.m_tlast !== 2'b00) begin n_fail++; $display("FAIL rm_valid_last: got %0b/%0b required 00/00", bus.m_tvalid, bus.m_tlast); end
        n_checks++; if (bus.m_tdata !== '0 || bus.m_tcount !== '0) begin n_fail++; $display("FAIL rm_data_count: got count %0h required 0 and zero data", bus.m_tcount); end
        n_checks++; if (busy !== 1'b0 || bus.s_tready !== 2'b00) begin n_fail++; $display("FAIL rm_busy_ready: got %0b/%0b required 0/00", busy, bus.s_tready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.s_tready !== 2'b11) begin n_fail++; $display("FAIL rm_ready_after: got %0b required 11", bus.s_tready); end
        send_word(1, 16'hD000, 12, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b00) begin n_fail++; $display("FAIL rm_routes_off: got %0b required 00", bus.m_tvalid); end
        load_route(4'b1110);
        send_word(0, 16'hE000, 12, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b11) begin n_fail++; $display("FAIL rm_fresh_valid: got %0b required 11", bus.m_tvalid); end
        n_checks++; if (bus.m_tdata[0 +: OUT_W] !== make_word(16'hE000, 12)) begin n_fail++; $display("FAIL rm_fresh_data: got %0h required %0h", bus.m_tdata[0 +: OUT_W], make_word(16'hE000, 12)); end
        n_checks++; if (bus.m_tcount[0 +: CNT_W] !== 4'd12) begin n_fail++; $display("FAIL rm_fresh_count: got %0d required 12", bus.m_tcount[0 +: CNT_W]); end
        n_checks++; if (bus.m_tdata[OUT_W +: OUT_W] !== make_word(16'hD000, 12)) begin n_fail++; $display("FAIL rm_ch1_data: got %0h required %0h", bus.m_tdata[OUT_W +: OUT_W], make_word(16'hD000, 12)); end
        bus.m_tready = 2'b11;
        @(negedge clk);
        n_checks++; if (bus.m_tvalid !== 2'b00) begin n_fail++; $display("FAIL rm_final_accept: got %0b required 00", bus.m_tvalid); end
        bus.m_tready = 2'b00;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_upsize();
        test_early_close();
        test_broadcast();
        test_route_change();
        test_disabled();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
